// File: rtl/food_map_rmw_ctrl.sv
// food_map_rmw_ctrl: eats pellets by read-modify-write of a food-map row and reloads the map from an external pattern source; ports: eat_* handshake, mem_* port A, fill_* loader, food_count/level_clear status
module food_map_rmw_ctrl #(
  parameter int ROWS  = 60,
  parameter int COLS  = 80,
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eat_valid,
  input  logic [6:0]       eat_x,
  input  logic [5:0]       eat_y,
  output logic             eat_ready,
  output logic             eat_done,
  output logic             eat_hit,
  input  logic             fill_req,
  output logic [5:0]       fill_addr,
  input  logic [COLS-1:0]  fill_data,
  output logic             fill_done,
  output logic [5:0]       mem_addr,
  output logic             mem_we,
  output logic [COLS-1:0]  mem_wdata,
  input  logic [COLS-1:0]  mem_rdata,
  output logic [CNT_W-1:0] food_count,
  output logic             level_clear
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, CAP = 3'd2, WR = 3'd3, FILL = 3'd4;
  localparam logic [5:0] LAST = 6'(ROWS - 1);
  logic [2:0]      state;
  logic [6:0]      ex;
  logic [5:0]      ey;
  logic            oor;
  logic            pend;
  logic            in_range;
  logic [COLS-1:0] row;
  function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] d);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < COLS; i++) s += CNT_W'(d[i]);
    return s;
  endfunction
  assign in_range  = 32'(eat_x) < COLS && 32'(eat_y) < ROWS;
  assign eat_ready = state == IDLE && !pend;
  assign eat_done  = state == WR;
  assign eat_hit   = state == WR && !oor && row[ex];
  assign mem_addr  = state == FILL ? fill_addr : ey;
  assign mem_we    = state == FILL || eat_hit;
  assign mem_wdata = state == FILL ? fill_data : row & ~(COLS'(1) << ex);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      ex          <= '0;
      ey          <= '0;
      oor         <= 1'b0;
      pend        <= 1'b0;
      row         <= '0;
      fill_addr   <= '0;
      food_count  <= '0;
      fill_done   <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      fill_done   <= state == FILL && fill_addr == LAST;
      level_clear <= eat_hit && food_count == CNT_W'(1);
      pend        <= state == IDLE && pend ? 1'b0 : state != FILL && fill_req ? 1'b1 : pend;
      case (state)
        IDLE:
          if (pend) begin
            state      <= FILL;
            fill_addr  <= '0;
            food_count <= '0;
          end else if (eat_valid) begin
            ex    <= eat_x;
            ey    <= eat_y;
            oor   <= !in_range;
            state <= in_range ? RD : WR;
          end
        RD: state <= CAP;
        CAP: begin
          row   <= mem_rdata;
          state <= WR;
        end
        WR: begin
          state <= IDLE;
          if (eat_hit && food_count != '0) food_count <= food_count - CNT_W'(1);
        end
        FILL: begin
          food_count <= food_count + popcount(fill_data);
          fill_addr  <= fill_addr == LAST ? '0 : fill_addr + 6'd1;
          state      <= fill_addr == LAST ? IDLE : FILL;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_food_map_rmw_ctrl.sv
// tb_food_map_rmw_ctrl: scoreboard bench for food_map_rmw_ctrl with a bit-level reference map and an external RAM model
module tb_food_map_rmw_ctrl;
  localparam int ROWS = 60, COLS = 80, CNT_W = 13;
  logic clk = 0, rst_n = 0, eat_valid = 0, fill_req = 0;
  logic [6:0] eat_x = 0;
  logic [5:0] eat_y = 0;
  logic eat_ready, eat_done, eat_hit, fill_done, mem_we, level_clear;
  logic [5:0] fill_addr, mem_addr;
  logic [COLS-1:0] fill_data, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] food_count;
  logic [COLS-1:0] mem [64];
  logic [COLS-1:0] pat [64];
  bit ref_map [ROWS][COLS];
  int ref_cnt = 0;
  int cyc = 0;
  int total = 0, passed = 0;
  typedef struct {
    int dc;
    bit hit;
    bit we;
    logic [5:0] y;
    logic [COLS-1:0] wd;
    int cnt;
    bit lc;
  } exp_t;
  exp_t eq[$];
  int fq[$];
  exp_t m_e;
  bit post = 0;
  int pcnt;
  bit plc;
  food_map_rmw_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
    .eat_ready(eat_ready), .eat_done(eat_done), .eat_hit(eat_hit), .fill_req(fill_req),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_done(fill_done), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .food_count(food_count),
    .level_clear(level_clear)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  assign fill_data = pat[fill_addr];
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic bad(input string n);
    total++;
    $display("FAIL %s", n);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (post) begin
      chk("food_count_after_eat", food_count, pcnt);
      chk("level_clear", level_clear, plc);
      post = 0;
    end else if (level_clear) bad("level_clear_stray");
    if (eat_done) begin
      if (eq.size() == 0) bad("eat_done_stray");
      else begin
        m_e = eq.pop_front();
        chk("done_cycle", cyc, m_e.dc);
        chk("eat_hit", eat_hit, m_e.hit);
        chk("mem_we_at_done", mem_we, m_e.we);
        if (m_e.we) begin
          chk("wr_addr", mem_addr, m_e.y);
          chk("wr_data", mem_wdata, m_e.wd);
        end
        pcnt = m_e.cnt;
        plc = m_e.lc;
        post = 1;
      end
    end
    if (fill_done) begin
      if (fq.size() == 0) bad("fill_done_stray");
      else begin
        int nb;
        chk("fill_count", food_count, fq.pop_front());
        nb = 0;
        for (int r = 0; r < ROWS; r++) if (mem[r] !== pat[r]) nb++;
        chk("fill_rows_written", nb, 0);
      end
    end
  end
  task automatic wait_ready();
    for (int i = 0; i < 300 && !eat_ready; i++) @(negedge clk);
    if (!eat_ready) bad("ready_timeout");
  endtask
  task automatic eat(input int x, input int y);
    exp_t e;
    bit o;
    wait_ready();
    eat_valid = 1;
    eat_x = 7'(x);
    eat_y = 6'(y);
    o = x >= COLS || y >= ROWS;
    e.dc = cyc + (o ? 1 : 3);
    e.hit = 0;
    e.wd = '0;
    if (!o) begin
      e.hit = ref_map[y][x];
      for (int i = 0; i < COLS; i++) e.wd[i] = ref_map[y][i];
      e.wd[x] = 1'b0;
    end
    e.we = e.hit;
    e.y = 6'(y);
    e.lc = e.hit && ref_cnt == 1;
    if (e.hit && ref_cnt > 0) ref_cnt--;
    if (e.hit) ref_map[y][x] = 0;
    e.cnt = ref_cnt;
    eq.push_back(e);
    @(negedge clk);
    eat_valid = 0;
    eat_x = 7'($urandom);
    eat_y = 6'($urandom);
  endtask
  task automatic start_fill();
    int s;
    s = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < COLS; i++) ref_map[r][i] = pat[r][i];
      s += $countones(pat[r]);
    end
    ref_cnt = s;
    fq.push_back(s);
    fill_req = 1;
    @(negedge clk);
    fill_req = 0;
  endtask
  task automatic wait_fill();
    for (int i = 0; i < 200 && fq.size() != 0; i++) @(negedge clk);
    if (fq.size() != 0) begin
      bad("fill_timeout");
      fq.delete();
    end
  endtask
  task automatic rand_pat();
    for (int r = 0; r < 64; r++)
      pat[r] = COLS'({$urandom, $urandom, $urandom}) & COLS'({$urandom, $urandom, $urandom});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int rdy_hi;
    for (int r = 0; r < 64; r++) begin
      mem[r] = '0;
      pat[r] = r < 2 ? '1 : '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_food_count", food_count, 0);
    chk("rst_eat_done", eat_done, 0);
    chk("rst_eat_hit", eat_hit, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_level_clear", level_clear, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_addr", fill_addr, 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", eat_ready, 1);
    start_fill();
    wait_fill();
    eat(5, 1);
    eat(5, 1);
    eat(80, 3);
    eat(3, 60);
    eat(127, 63);
    eat(79, 0);
    eat(0, 59);
    rand_pat();
    eat(10, 0);
    @(negedge clk);
    start_fill();
    rdy_hi = 0;
    for (int i = 0; i < 200 && !fill_done; i++) begin
      if (eat_ready) rdy_hi++;
      @(negedge clk);
    end
    chk("ready_low_until_fill_done", rdy_hi, 0);
    chk("fill_done_after_cap_req", fill_done, 1);
    wait_fill();
    for (int k = 0; k < 120; k++) eat($urandom_range(0, 84), $urandom_range(0, 63));
    for (int r = 0; r < 64; r++) pat[r] = '0;
    pat[7][33] = 1'b1;
    start_fill();
    wait_fill();
    eat(33, 7);
    eat(33, 7);
    pat[7] = '0;
    start_fill();
    wait_fill();
    eat(0, 0);
    rand_pat();
    start_fill();
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midfill_rst_mem_we", mem_we, 0);
    chk("midfill_rst_count", food_count, 0);
    chk("midfill_rst_fill_addr", fill_addr, 0);
    fq.delete();
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("ready_after_midfill_reset", eat_ready, 1);
    rand_pat();
    start_fill();
    wait_fill();
    for (int k = 0; k < 30; k++) eat($urandom_range(0, 84), $urandom_range(0, 63));
    for (int i = 0; i < 50 && eq.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queues_drained", eq.size() + fq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
